// File: rtl/alu_iterative_if.sv
// Request/response bundle between the ALU issue logic and the iterative ALU.
// The master drives start and operands; the slave returns busy, done and the registered result.
interface alu_iterative_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [3:0]            Operation;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  Zero;

    modport master (
        output start, Operation, SrcA, SrcB,
        input  busy, done, ALUResult, Zero
    );

    modport slave (
        input  start, Operation, SrcA, SrcB,
        output busy, done, ALUResult, Zero
    );
endinterface

// File: rtl/alu_iterative.sv
// Execution-stage ALU: one-cycle logic/arith ops and a bit-serial shifter behind start/busy/done.
// Defining ALU_BARREL_SHIFT_EN replaces the serial shifter with a one-cycle barrel shifter.
module alu_iterative #(
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    alu_iterative_if.slave bus
);
    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;

    // Shifts only appear here with a zero amount in the serial build, so they pass A through.
    function automatic logic [DATA_WIDTH-1:0] single_cycle_result(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        r = {DATA_WIDTH{1'b0}};
        case (op)
            OP_AND:  r = a & b;
            OP_SUB:  r = a - b;
            OP_ADD:  r = a + b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_EQ:   r = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
            OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL:  r = a << b[SHW-1:0];
            OP_SRL:  r = a >> b[SHW-1:0];
            OP_SRA:  r = $signed(a) >>> b[SHW-1:0];
`else
            OP_SLL:  r = a;
            OP_SRL:  r = a;
            OP_SRA:  r = a;
`endif
            default: r = {DATA_WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] result_r;
    logic [DATA_WIDTH-1:0] result_nx_s;
    logic                  result_ld_s;
    logic                  zero_r;
    logic                  done_r;

    assign bus.ALUResult = result_r;
    assign bus.Zero      = zero_r;
    assign bus.done      = done_r;

`ifdef ALU_BARREL_SHIFT_EN
    assign bus.busy = 1'b0;

    // Every accepted start completes at the next edge.
    always_comb begin
        result_ld_s = bus.start;
        result_nx_s = single_cycle_result(bus.Operation, bus.SrcA, bus.SrcB);
    end
`else
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};

    function automatic logic [DATA_WIDTH-1:0] shift_one(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] v
    );
        logic [DATA_WIDTH-1:0] r;
        r = v;
        case (op)
            OP_SLL:  r = {v[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[DATA_WIDTH-1:1]};
            OP_SRA:  r = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    state_t                state_r;
    state_t                state_nx_s;
    logic [DATA_WIDTH-1:0] shreg_r;
    logic [DATA_WIDTH-1:0] shreg_step_s;
    logic [SHW-1:0]        cnt_r;
    logic [3:0]            op_r;
    logic                  busy_r;
    logic [SHW-1:0]        shamt_s;
    logic                  is_shift_s;
    logic                  launch_s;

    assign shamt_s      = bus.SrcB[SHW-1:0];
    assign is_shift_s   = (bus.Operation == OP_SLL) || (bus.Operation == OP_SRL) ||
                          (bus.Operation == OP_SRA);
    assign launch_s     = (state_r == ST_IDLE) && bus.start && is_shift_s && (shamt_s != CNT_ZERO);
    assign shreg_step_s = shift_one(op_r, shreg_r);
    assign bus.busy     = busy_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state: leave IDLE only for a non-zero shift, return after the last bit.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_ONE) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode: which edge writes the result, and with what value.
    always_comb begin
        result_ld_s = 1'b0;
        result_nx_s = result_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && !launch_s) begin
                    result_ld_s = 1'b1;
                    result_nx_s = single_cycle_result(bus.Operation, bus.SrcA, bus.SrcB);
                end else begin
                    result_ld_s = 1'b0;
                    result_nx_s = result_r;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_ONE) begin
                    result_ld_s = 1'b1;
                    result_nx_s = shreg_step_s;
                end else begin
                    result_ld_s = 1'b0;
                    result_nx_s = result_r;
                end
            end
            default: begin
                result_ld_s = 1'b0;
                result_nx_s = result_r;
            end
        endcase
    end

    // Serial shift datapath: operands are captured at accept so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r <= {DATA_WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            op_r    <= 4'b0000;
            busy_r  <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == ST_SHIFT);
            if (launch_s) begin
                shreg_r <= bus.SrcA;
                cnt_r   <= shamt_s;
                op_r    <= bus.Operation;
            end else if (state_r == ST_SHIFT) begin
                shreg_r <= shreg_step_s;
                cnt_r   <= cnt_r - CNT_ONE;
            end
        end
    end
`endif

    // Result, Zero and the done pulse update together on a completing edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= {DATA_WIDTH{1'b0}};
            zero_r   <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            done_r <= result_ld_s;
            if (result_ld_s) begin
                result_r <= result_nx_s;
                zero_r   <= (result_nx_s == {DATA_WIDTH{1'b0}});
            end
        end
    end
endmodule

// File: tb/tb_alu_iterative.sv
// Directed-vector bench for alu_iterative; expected results and latencies are hand-computed.
module tb_alu_iterative;
`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;

    alu_iterative_if #(.DATA_WIDTH(32)) bus_if ();

    alu_iterative #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_value({tag, " busy"}, {31'd0, bus_if.busy}, 32'd0);
        check_value({tag, " done"}, {31'd0, bus_if.done}, 32'd0);
        check_value({tag, " result"}, bus_if.ALUResult, 32'd0);
        check_value({tag, " zero"}, {31'd0, bus_if.Zero}, 32'd1);
    endtask

    // Issue one op, wait (bounded) for done, then check result, latency, busy count and pulse width.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int busy_cyc;
        bit seen;
        @(negedge clk);
        bus_if.start     = 1'b1;
        bus_if.Operation = op;
        bus_if.SrcA      = a;
        bus_if.SrcB      = b;
        lat      = 0;
        busy_cyc = 0;
        seen     = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            bus_if.start = 1'b0;
            if (bus_if.done) seen = 1'b1;
            else if (bus_if.busy) busy_cyc++;
        end
        check_value({tag, " latency"}, lat, exp_lat);
        check_value({tag, " result"}, bus_if.ALUResult, exp_res);
        check_value({tag, " zero"}, {31'd0, bus_if.Zero}, {31'd0, (exp_res == 32'd0)});
        check_value({tag, " busy cycles"}, busy_cyc, exp_lat - 1);
        check_value({tag, " busy at done"}, {31'd0, bus_if.busy}, 32'd0);
        @(negedge clk);
        check_value({tag, " done pulse"}, {31'd0, bus_if.done}, 32'd0);
        check_value({tag, " held"}, bus_if.ALUResult, exp_res);
    endtask

    initial begin
        int lat;
        int extra;
        vec_cnt          = 0;
        err_cnt          = 0;
        reset            = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.Operation = 4'b0000;
        bus_if.SrcA      = 32'd0;
        bus_if.SrcB      = 32'd0;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset");
        @(negedge clk);
        check_reset_state("idle after reset");

        run_op("ADD ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
        run_op("SUB eq",  4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1);
        run_op("SUB wrap", 4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1);
        run_op("AND",     4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1);
        run_op("OR",      4'b0011, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1);
        run_op("XOR",     4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1);
        run_op("SLT neg", 4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
        run_op("SLT pos", 4'b1001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("EQ same", 4'b1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0001, 1);
        run_op("EQ diff", 4'b1000, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 32'h0000_0000, 1);
        run_op("op 1100", 4'b1100, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1);

        run_op("SRA 4",   4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, BARREL ? 1 : 5);
        run_op("SRL 4",   4'b0110, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, BARREL ? 1 : 5);
        run_op("SLL 0",   4'b0101, 32'h0000_0001, 32'hFFFF_FFE0, 32'h0000_0001, 1);
        run_op("SLL 31",  4'b0101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, BARREL ? 1 : 32);

        // start held high while busy; inputs scrambled after accept must not matter.
        @(negedge clk);
        bus_if.start     = 1'b1;
        bus_if.Operation = 4'b0110;
        bus_if.SrcA      = 32'h0000_00F0;
        bus_if.SrcB      = 32'h0000_0003;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus_if.done) break;
            bus_if.Operation = 4'b0010;
            bus_if.SrcA      = 32'h1111_1111;
            bus_if.SrcB      = 32'h0000_0007;
        end
        bus_if.start = 1'b0;
        check_value("hold latency", lat, BARREL ? 1 : 4);
        check_value("hold result", bus_if.ALUResult, 32'h0000_001E);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_if.done) extra++;
        end
        check_value("hold extra dones", extra, 0);

        // Back-to-back: a new start in the done cycle completes one cycle later.
        @(negedge clk);
        bus_if.start     = 1'b1;
        bus_if.Operation = 4'b0110;
        bus_if.SrcA      = 32'h8000_0000;
        bus_if.SrcB      = 32'h0000_0002;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            bus_if.start = 1'b0;
            if (bus_if.done) break;
        end
        check_value("b2b first latency", lat, BARREL ? 1 : 3);
        check_value("b2b first result", bus_if.ALUResult, 32'h2000_0000);
        bus_if.start     = 1'b1;
        bus_if.Operation = 4'b0010;
        bus_if.SrcA      = 32'h0000_0002;
        bus_if.SrcB      = 32'h0000_0003;
        @(negedge clk);
        bus_if.start = 1'b0;
        check_value("b2b second done", {31'd0, bus_if.done}, 32'd1);
        check_value("b2b second result", bus_if.ALUResult, 32'h0000_0005);

        // Reset in the middle of a long shift discards the partial result.
        @(negedge clk);
        bus_if.start     = 1'b1;
        bus_if.Operation = 4'b0101;
        bus_if.SrcA      = 32'h0000_0001;
        bus_if.SrcB      = 32'h0000_0014;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (2) @(negedge clk);
        check_value("mid-shift busy", {31'd0, bus_if.busy}, {31'd0, !BARREL});
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("mid-shift reset");
        reset = 1'b0;
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus_if.done || bus_if.busy) extra++;
        end
        check_value("after reset quiet", extra, 0);
        check_value("after reset result", bus_if.ALUResult, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
